hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage LEGv8 core: generates PC/IF-ID write enables, ID/EX bubble
//  and stage flushes. Covers the load-use hazards that operand forwarding cannot resolve, taken-branch
//  flushes, and freezing the whole pipeline while a data-memory access waits for its ack.
//  Sits beside the forwarding unit; owns every stall/flush control of the pipeline registers.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEMWAIT before mem_err; 0 = no timeout
//  PERFW        32  width of perf counters (HAZARD_PERF_EN only)
// PORTS
//  clk           in   1            pipeline clock
//  rst_n         in   1            async active-low reset
//  idex_memread  in   1            ID/EX instr is a load
//  idex_rd       in   REGADDRSIZE  ID/EX destination reg
//  ifid_ra       in   REGADDRSIZE  IF/ID source reg A
//  ifid_rb       in   REGADDRSIZE  IF/ID source reg B
//  ifid_uses_rb  in   1            IF/ID instr reads rb (0 for imm forms)
//  exmem_taken   in   1            branch resolved taken in MEM
//  dmem_req      in   1            EX/MEM instr accesses data memory this cycle
//  dmem_ack      in   1            data memory completes access
//  pc_write      out  1            PC update enable
//  ifid_write    out  1            IF/ID register enable
//  idex_bubble   out  1            load ID/EX with NOP controls
//  ifid_flush / idex_flush / exmem_flush  out 1 each  clear stage register
//  pipe_hold     out  1            freeze ID/EX, EX/MEM, MEM/WB
//  mem_err       out  1            sticky memory-timeout flag
// BEHAVIOUR
//  - Clock is clk; reset is asynchronous, active-low on rst_n. All state resets to INIT, wait_cnt=0, mem_err=0.
//  - While rst_n=0: pc_write=0, ifid_write=0, all flushes=1, idex_bubble=0, pipe_hold=0, mem_err=0.
//  - States (registered; outputs combinational from state + inputs):
//    INIT: flushes=1, pc_write=0, ifid_write=0; next RUN unconditionally (exactly 1 cycle).
//    RUN, priority high->low:
//     1 dmem_req & !dmem_ack: pipe_hold=1, pc_write=0, ifid_write=0; next MEMWAIT, wait_cnt=1.
//     2 exmem_taken: ifid_flush=idex_flush=exmem_flush=1, pc_write=1 (branch target); no load-use stall.
//     3 load-use: idex_memread & idex_rd!=XZR & (idex_rd==ifid_ra | (ifid_uses_rb & idex_rd==ifid_rb))
//       -> pc_write=0, ifid_write=0, idex_bubble=1 for that cycle only (bubble clears idex_memread).
//     4 else pc_write=ifid_write=1, all others 0.
//     dmem_req & dmem_ack same cycle: zero-wait, no hold; rules 2-4 apply.
//    MEMWAIT: pipe_hold=1, pc_write=ifid_write=0, no flush/bubble; exmem_taken, load-use ignored.
//     dmem_ack -> RUN, wait_cnt=0; next cycle re-evaluates RUN rules with the held stage contents.
//     !dmem_ack & MEM_TIMEOUT!=0 & wait_cnt==MEM_TIMEOUT -> ERROR, mem_err=1; else wait_cnt++.
//    ERROR: pipe_hold=1, pc_write=ifid_write=0, mem_err=1; exit only via reset.
//  - wait_cnt width = $clog2(MEM_TIMEOUT+1), min 1; saturates, never wraps.
//  - Reset mid-MEMWAIT/ERROR: immediate return to INIT semantics; pending ack discarded.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_loaduse, perf_memwait, perf_flush [PERFW-1:0], counting
//   RUN-rule-3 cycles, MEMWAIT cycles, RUN-rule-2 cycles; reset to 0, wrap at 2^PERFW.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  hazard.vh: state encodings HZ_INIT/HZ_RUN/HZ_MEMWAIT/HZ_ERROR, HZSTATESIZE; reuse XZR,
//   REGADDRSIZE from registers.vh.
//  Sub-module hazard_perf (three counters + increment strobes), instantiated only under HAZARD_PERF_EN.
// TESTING
//  1 rst_n low 3 cyc then high -> INIT 1 cyc (all flush=1, pc_write=0), then RUN, pc_write=1.
//  2 idex_memread=1, idex_rd=X3, ifid_ra=X3 -> 1 cyc pc_write=0, idex_bubble=1; idex_rd=XZR -> no stall.
//  3 ifid_rb=X5=idex_rd, ifid_uses_rb=0 -> no stall; ifid_uses_rb=1 -> stall.
//  4 dmem_req=1, ack after 4 cyc -> pipe_hold=1 for 4 cyc, RUN next; exmem_taken held -> flush after.
//  5 MEM_TIMEOUT=4, no ack -> mem_err=1 after 4 MEMWAIT cycles, stays; rst_n low clears it.
//  6 exmem_taken & load-use same cycle -> 3 flushes, pc_write=1, idex_bubble=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard sequencer.
// Register-file addressing, sequencer state encoding and the load-use detection helper.
package hazard_ctrl_pkg;

  localparam int REGADDRSIZE = 5;
  localparam logic [REGADDRSIZE-1:0] XZR = 5'd31;

  localparam int HZSTATESIZE = 2;

  typedef enum logic [HZSTATESIZE-1:0] {
    HZ_INIT    = 2'd0,
    HZ_RUN     = 2'd1,
    HZ_MEMWAIT = 2'd2,
    HZ_ERROR   = 2'd3
  } hz_state_e;

  // XZR is never written, so a load targeting it cannot create a dependency.
  function automatic logic load_use_hit(
    input logic                   memread,
    input logic [REGADDRSIZE-1:0] rd,
    input logic [REGADDRSIZE-1:0] ra,
    input logic [REGADDRSIZE-1:0] rb,
    input logic                   uses_rb
  );
    return memread && (rd != XZR) && ((rd == ra) || (uses_rb && (rd == rb)));
  endfunction

endpackage

// File: rtl/hazard_perf.sv
// Event counters for the hazard sequencer: load-use stalls, memory-wait cycles and branch flushes.
// Counters wrap at 2^PERFW.
module hazard_perf #(
  parameter int PERFW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_loaduse,
  input  logic             inc_memwait,
  input  logic             inc_flush,
  output logic [PERFW-1:0] perf_loaduse,
  output logic [PERFW-1:0] perf_memwait,
  output logic [PERFW-1:0] perf_flush
);

  logic [PERFW-1:0] loaduse_r;
  logic [PERFW-1:0] memwait_r;
  logic [PERFW-1:0] flush_r;

  // Event counters, one increment per strobed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaduse_r <= {PERFW{1'b0}};
      memwait_r <= {PERFW{1'b0}};
      flush_r   <= {PERFW{1'b0}};
    end else begin
      if (inc_loaduse) begin
        loaduse_r <= loaduse_r + PERFW'(1'b1);
      end
      if (inc_memwait) begin
        memwait_r <= memwait_r + PERFW'(1'b1);
      end
      if (inc_flush) begin
        flush_r <= flush_r + PERFW'(1'b1);
      end
    end
  end

  assign perf_loaduse = loaduse_r;
  assign perf_memwait = memwait_r;
  assign perf_flush   = flush_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage LEGv8 core: PC/IF-ID enables, ID/EX bubble, stage flushes, memory hold.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERFW       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   idex_memread,
  input  logic [REGADDRSIZE-1:0] idex_rd,
  input  logic [REGADDRSIZE-1:0] ifid_ra,
  input  logic [REGADDRSIZE-1:0] ifid_rb,
  input  logic                   ifid_uses_rb,
  input  logic                   exmem_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ack,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_bubble,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   pipe_hold,
  output logic                   mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERFW-1:0]       perf_loaduse,
  output logic [PERFW-1:0]       perf_memwait,
  output logic [PERFW-1:0]       perf_flush
`endif
);

  localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] CNT_MAX     = {WCW{1'b1}};
  localparam logic [WCW-1:0] CNT_LIMIT   = WCW'(MEM_TIMEOUT);
  localparam logic           TIMEOUT_ON  = (MEM_TIMEOUT != 0);

  if (MEM_TIMEOUT < 0 || PERFW < 1) begin : g_bad_param
    $error("hazard_ctrl: MEM_TIMEOUT must be >= 0 and PERFW >= 1");
  end

  hz_state_e      state_r;
  logic [WCW-1:0] wait_cnt_r;
  logic           mem_err_r;

  logic mem_stall_s;
  logic lu_hit_s;
  logic pc_write_s;
  logic ifid_write_s;
  logic idex_bubble_s;
  logic ifid_flush_s;
  logic idex_flush_s;
  logic exmem_flush_s;
  logic pipe_hold_s;

  assign mem_stall_s = dmem_req && !dmem_ack;
  assign lu_hit_s    = load_use_hit(idex_memread, idex_rd, ifid_ra, ifid_rb, ifid_uses_rb);

  // Sequencer state, memory-wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HZ_INIT;
      wait_cnt_r <= {WCW{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        HZ_INIT: begin
          state_r    <= HZ_RUN;
          wait_cnt_r <= {WCW{1'b0}};
        end
        HZ_RUN: begin
          if (mem_stall_s) begin
            state_r    <= HZ_MEMWAIT;
            wait_cnt_r <= WCW'(1'b1);
          end else begin
            state_r    <= HZ_RUN;
            wait_cnt_r <= {WCW{1'b0}};
          end
        end
        HZ_MEMWAIT: begin
          if (dmem_ack) begin
            state_r    <= HZ_RUN;
            wait_cnt_r <= {WCW{1'b0}};
          end else if (TIMEOUT_ON && (wait_cnt_r == CNT_LIMIT)) begin
            state_r   <= HZ_ERROR;
            mem_err_r <= 1'b1;
          end else if (wait_cnt_r != CNT_MAX) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1'b1);
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        HZ_ERROR: begin
          state_r   <= HZ_ERROR;
          mem_err_r <= 1'b1;
        end
        default: begin
          state_r    <= HZ_INIT;
          wait_cnt_r <= {WCW{1'b0}};
        end
      endcase
    end
  end

  // Stage-register controls decoded from state and the current hazard inputs.
  always_comb begin
    pc_write_s    = 1'b0;
    ifid_write_s  = 1'b0;
    idex_bubble_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    pipe_hold_s   = 1'b0;
    case (state_r)
      HZ_INIT: begin
        ifid_flush_s  = 1'b1;
        idex_flush_s  = 1'b1;
        exmem_flush_s = 1'b1;
      end
      HZ_RUN: begin
        if (mem_stall_s) begin
          pipe_hold_s = 1'b1;
        end else if (exmem_taken) begin
          // A taken branch squashes the dependent younger instruction, so no stall is needed.
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          pc_write_s    = 1'b1;
        end else if (lu_hit_s) begin
          idex_bubble_s = 1'b1;
        end else begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
        end
      end
      HZ_MEMWAIT: begin
        pipe_hold_s = 1'b1;
      end
      HZ_ERROR: begin
        pipe_hold_s = 1'b1;
      end
      default: begin
        ifid_flush_s  = 1'b1;
        idex_flush_s  = 1'b1;
        exmem_flush_s = 1'b1;
      end
    endcase
  end

  assign pc_write    = pc_write_s;
  assign ifid_write  = ifid_write_s;
  assign idex_bubble = idex_bubble_s;
  assign ifid_flush  = ifid_flush_s;
  assign idex_flush  = idex_flush_s;
  assign exmem_flush = exmem_flush_s;
  assign pipe_hold   = pipe_hold_s;
  assign mem_err     = mem_err_r;

`ifdef HAZARD_PERF_EN
  logic inc_loaduse_s;
  logic inc_memwait_s;
  logic inc_flush_s;

  assign inc_loaduse_s = (state_r == HZ_RUN) && !mem_stall_s && !exmem_taken && lu_hit_s;
  assign inc_memwait_s = (state_r == HZ_MEMWAIT);
  assign inc_flush_s   = (state_r == HZ_RUN) && !mem_stall_s && exmem_taken;

  hazard_perf #(
    .PERFW(PERFW)
  ) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_loaduse  (inc_loaduse_s),
    .inc_memwait  (inc_memwait_s),
    .inc_flush    (inc_flush_s),
    .perf_loaduse (perf_loaduse),
    .perf_memwait (perf_memwait),
    .perf_flush   (perf_flush)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4; outputs are packed into one vector and
// compared mid-cycle against hand-derived control patterns.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = 5'd0;
  logic [4:0] ifid_ra = 5'd0;
  logic [4:0] ifid_rb = 5'd0;
  logic       ifid_uses_rb = 1'b0;
  logic       exmem_taken = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_err;

  int n_total = 0;
  int n_bad   = 0;

  // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_err}
  localparam logic [7:0] V_INIT  = 8'b0001_1100;
  localparam logic [7:0] V_RUN   = 8'b1100_0000;
  localparam logic [7:0] V_STALL = 8'b0010_0000;
  localparam logic [7:0] V_FLUSH = 8'b1001_1100;
  localparam logic [7:0] V_HOLD  = 8'b0000_0010;
  localparam logic [7:0] V_ERR   = 8'b0000_0011;

  logic [7:0] obs;
  assign obs = {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_err};

  hazard_ctrl #(.MEM_TIMEOUT(4), .PERFW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_ra      (ifid_ra),
    .ifid_rb      (ifid_rb),
    .ifid_uses_rb (ifid_uses_rb),
    .exmem_taken  (exmem_taken),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pipe_hold    (pipe_hold),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic urb, input logic tk, input logic rq, input logic ak);
    idex_memread = mr; idex_rd = rd; ifid_ra = ra; ifid_rb = rb;
    ifid_uses_rb = urb; exmem_taken = tk; dmem_req = rq; dmem_ack = ak;
  endtask

  // Check mid-cycle, then move to just after the next rising edge.
  task automatic look(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) look("reset", V_INIT);
    rst_n = 1'b1;
    look("init", V_INIT);
    look("run_idle", V_RUN);

    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    look("lu_ra", V_STALL);
    drive(1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    look("lu_after_bubble", V_RUN);
    drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    look("lu_xzr", V_RUN);
    drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    look("lu_rb_unused", V_RUN);
    drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    look("lu_rb_used", V_STALL);
    drive(1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    look("zero_wait_taken", V_FLUSH);
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    look("zero_wait_lu", V_STALL);

    // Memory wait acked on the fourth hold cycle; branch and load-use must be ignored meanwhile.
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    look("mw_enter", V_HOLD);
    look("mw_1", V_HOLD);
    look("mw_2", V_HOLD);
    dmem_ack = 1'b1;
    look("mw_ack", V_HOLD);
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    look("taken_and_lu", V_FLUSH);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    look("run_after_flush", V_RUN);

    // Timeout: four MEMWAIT cycles without ack, then sticky error.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    look("to_enter", V_HOLD);
    look("to_w1", V_HOLD);
    look("to_w2", V_HOLD);
    look("to_w3", V_HOLD);
    look("to_w4", V_HOLD);
    look("to_err", V_ERR);
    dmem_ack = 1'b1;
    look("err_late_ack", V_ERR);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    look("err_sticky", V_ERR);
    rst_n = 1'b0;
    look("err_reset", V_INIT);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    look("reinit", V_INIT);
    look("rerun", V_RUN);

    // Reset in the middle of a wait discards the pending ack.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    look("mw2_enter", V_HOLD);
    look("mw2_1", V_HOLD);
    dmem_ack = 1'b1;
    rst_n = 1'b0;
    look("mw2_reset", V_INIT);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    look("mw2_init", V_INIT);
    look("mw2_run", V_RUN);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
